// File: rtl/ysyx_22051145_ifstage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051145_ifstage
// Description : Instruction fetch stage. It keeps the program counter and
//               issues at most one instruction-memory request at a time. It
//               holds the fetched word for decode until decode consumes it,
//               and it drops any in-flight response made stale by a redirect.
// Ports       : clk, rst_n                  - clock, synchronous active-low reset
//               req_valid/req_ready/req_addr - instruction memory request
//               resp_valid/resp_data         - instruction memory response
//               inst_valid/inst_ready/inst_o/pc_o - handshake to decode
//               redirect_valid/redirect_pc   - redirect from a later stage
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051145_ifstage #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [63:0] req_addr,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_o,
   output logic [63:0] pc_o,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc
);

   // S_REQ : request for pc is being presented
   // S_WAIT: request accepted, waiting for a response that will be kept
   // S_DROP: request accepted, but its response is stale and will be dropped
   // S_HOLD: instruction is presented to decode
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] pc_o_q, pc_o_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] redirect_target;

   // Redirect targets are forced to word alignment.
   assign redirect_target = {redirect_pc[63:2], 2'b00};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         pc_o_q  <= 64'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         pc_o_q  <= pc_o_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      pc_o_d  = pc_o_q;

      // A redirect always retargets pc; the state-specific code below only
      // decides what happens to the current transaction.
      if (redirect_valid) begin
         pc_d = redirect_target;
      end

      case (state_q)
         S_REQ: begin
            if (redirect_valid) begin
               // An accepted old-pc request still owes us a response.
               if (req_ready) state_d = S_DROP;
            end else if (req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               // A response arriving with the redirect is simply discarded.
               state_d = resp_valid ? S_REQ : S_DROP;
            end else if (resp_valid) begin
               inst_d  = resp_data;
               pc_o_d  = pc_q;
               state_d = S_HOLD;
            end
         end
         S_DROP: begin
            // A redirect here only moves pc; the stale response is still awaited.
            if (resp_valid) state_d = S_REQ;
         end
         S_HOLD: begin
            if (redirect_valid) begin
               state_d = S_REQ;
            end else if (inst_ready) begin
               pc_d    = pc_q + 64'd4;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // Handshake valids are masked during reset so they read 0 immediately.
   assign req_valid  = rst_n && (state_q == S_REQ);
   assign req_addr   = pc_q;
   assign inst_valid = rst_n && (state_q == S_HOLD);
   assign inst_o     = inst_q;
   assign pc_o       = pc_o_q;

endmodule
`default_nettype wire
